// File: rtl/mdu_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } mdu_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Core <-> multiply/divide unit bus: operation launch, MTHI/MTLO writes and HI/LO results.
interface mult_div_unit_if import mdu_pkg::*; #(
    parameter int WIDTH = MDU_WIDTH
);
    logic             START;
    logic [1:0]       OP;
    logic [WIDTH-1:0] SRC_A;
    logic [WIDTH-1:0] SRC_B;
    logic             HI_WE;
    logic             LO_WE;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output START, OP, SRC_A, SRC_B, HI_WE, LO_WE,
        input  BUSY, DONE, HI, LO
    );

    modport slave (
        input  START, OP, SRC_A, SRC_B, HI_WE, LO_WE,
        output BUSY, DONE, HI, LO
    );
endinterface

// File: rtl/mdu_sign_fix.sv
// Combinational sign handling: operand magnitudes at launch and the final
// negation of product, quotient or remainder.
module mdu_sign_fix import mdu_pkg::*; #(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             is_signed,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] abs_a,
    output logic [WIDTH-1:0] abs_b,
    input  logic             is_div,
    input  logic             neg_q,
    input  logic             neg_r,
    input  logic [WIDTH-1:0] hi_raw,
    input  logic [WIDTH-1:0] lo_raw,
    output logic [WIDTH-1:0] hi_fix,
    output logic [WIDTH-1:0] lo_fix
);
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_neg;

    assign abs_a    = (is_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    assign abs_b    = (is_signed && src_b[WIDTH-1]) ? -src_b : src_b;
    assign prod     = {hi_raw, lo_raw};
    assign prod_neg = -prod;

    // A product is negated as one 2*WIDTH value; quotient and remainder independently.
    always_comb begin
        hi_fix = hi_raw;
        lo_fix = lo_raw;
        if (is_div) begin
            if (neg_q) lo_fix = -lo_raw;
            if (neg_r) hi_fix = -hi_raw;
        end else if (neg_q) begin
            hi_fix = prod_neg[2*WIDTH-1:WIDTH];
            lo_fix = prod_neg[WIDTH-1:0];
        end
    end
endmodule

// File: rtl/mult_div_unit.sv
// Radix-2 iterative multiply/divide unit with HI/LO result registers.
// Divide support is compiled only when MDU_DIV_EN is defined.
module mult_div_unit import mdu_pkg::*; #(
    parameter int WIDTH    = MDU_WIDTH,
    parameter int CNT_BITS = 5
) (
    input  logic           CLK,
    input  logic           RST,
    mult_div_unit_if.slave bus
);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(WIDTH - 1);

    mdu_state_e          state;
    logic [CNT_BITS-1:0] cnt;
    logic [WIDTH-1:0]    acc;
    logic [WIDTH-1:0]    ql;
    logic [WIDTH-1:0]    opb;
    logic [WIDTH-1:0]    hi_q;
    logic [WIDTH-1:0]    lo_q;
    logic                busy_q;
    logic                done_q;
    logic                is_div;
    logic                neg_q;
    logic                neg_r;

    logic                op_signed;
    logic                op_div;
    logic                launch;
    logic                b_zero;
    logic [WIDTH-1:0]    abs_a;
    logic [WIDTH-1:0]    abs_b;
    logic [WIDTH-1:0]    hi_fix;
    logic [WIDTH-1:0]    lo_fix;
    logic [WIDTH:0]      mul_sum;

    assign op_signed = ~bus.OP[0];
    assign b_zero    = (bus.SRC_B == '0);

`ifdef MDU_DIV_EN
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_diff;

    assign op_div    = bus.OP[1];
    assign launch    = bus.START;
    assign div_shift = {acc, ql[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb};
`else
    assign op_div    = 1'b0;
    assign launch    = bus.START & ~bus.OP[1];
`endif

    assign mul_sum = {1'b0, acc} + {1'b0, (ql[0] ? opb : '0)};

    mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .is_signed (op_signed),
        .src_a     (bus.SRC_A),
        .src_b     (bus.SRC_B),
        .abs_a     (abs_a),
        .abs_b     (abs_b),
        .is_div    (is_div),
        .neg_q     (neg_q),
        .neg_r     (neg_r),
        .hi_raw    (acc),
        .lo_raw    (ql),
        .hi_fix    (hi_fix),
        .lo_fix    (lo_fix)
    );

    // A zero divisor leaves an all-ones quotient and |A| as remainder; skipping only
    // the quotient negation lets the remainder sign fix restore the original A.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            ql     <= '0;
            opb    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        is_div <= op_div;
                        neg_q  <= op_signed && (bus.SRC_A[WIDTH-1] ^ bus.SRC_B[WIDTH-1])
                                  && !(op_div && b_zero);
                        neg_r  <= op_signed && op_div && bus.SRC_A[WIDTH-1];
                        ql     <= abs_a;
                        opb    <= abs_b;
                        acc    <= '0;
                        cnt    <= CNT_LAST;
                        busy_q <= 1'b1;
                        state  <= CALC;
                    end else begin
                        if (bus.HI_WE) hi_q <= bus.SRC_A;
                        if (bus.LO_WE) lo_q <= bus.SRC_A;
                    end
                end
                CALC: begin
`ifdef MDU_DIV_EN
                    if (is_div) begin
                        acc <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                        ql  <= {ql[WIDTH-2:0], ~div_diff[WIDTH]};
                    end else
`endif
                    begin
                        acc <= mul_sum[WIDTH:1];
                        ql  <= {mul_sum[0], ql[WIDTH-1:1]};
                    end
                    if (cnt == '0) state <= FIX;
                    else           cnt   <= cnt - CNT_BITS'(1);
                end
                FIX: begin
                    hi_q   <= hi_fix;
                    lo_q   <= lo_fix;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
endmodule
